maxpool2x2: RTL and testbench

Streaming 2×2 / stride-2 max-pooling stage placed directly downstream of `conv`. Consumes the convolution's raster-ordered 32-bit signed result stream (26×26 for a 28×28 input and 3×3 kernel) and emits a 13×13 pooled map in raster order. A single half-row line buffer keeps the design fully streaming, with no backpressure.

---
 rtl/maxpool2x2.sv | 171 +++++++++++++++++
 tb/tb_maxpool2x2.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2.sv
// -----------------------------------------------------------------------------
// maxpool2x2
//
// Streaming 2x2 / stride-2 max-pooling stage. Consumes a raster-ordered stream
// of signed samples (IN_W columns x IN_H rows per frame) and produces the
// floor(IN_W/2) x floor(IN_H/2) pooled map in raster order. Only one half-row
// line buffer is kept: even rows fold each horizontal pair into the buffer,
// odd rows fold their own pair against the buffered value and emit the result.
// There is no backpressure; the input may stall (gaps) at any time.
//
// Optional build macro:
//   MAXPOOL_RELU_EN  when defined, negative pooled results are clamped to zero
//                    (ReLU fused after pooling). Timing is identical.
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   synchronous, active-high
//   conv_out      in   DATA_W signed input sample
//   conv_invalid  in   active-low input qualifier (0 = sample accepted)
//   conv_finish   in   frame resync; clears position/state, drops same-edge sample
//   pool_out      out  DATA_W pooled sample, registered
//   pool_invalid  out  active-low output qualifier, 0 for one cycle per result
//   pool_finish   out  one-cycle pulse with the last pooled sample of a frame
//
// States:
//   S_EVEN | even input row: pair up samples, write pair max into linebuf
//   S_ODD  | odd input row:  pair up samples, combine with linebuf, emit result
// -----------------------------------------------------------------------------
module maxpool2x2 #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 26,
    parameter int IN_H   = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] conv_out,
    input  logic              conv_invalid,
    input  logic              conv_finish,
    output logic [DATA_W-1:0] pool_out,
    output logic              pool_invalid,
    output logic              pool_finish
);

    localparam int OUT_W = IN_W / 2;
    localparam int OUT_H = IN_H / 2;
    localparam int LB_D  = (OUT_W > 0) ? OUT_W : 1;
    localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    localparam bit H_ODD = (IN_H % 2) == 1;

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IN_H - 1);
    localparam logic [COL_W-1:0] POOL_COL_LAST = COL_W'(2 * OUT_W - 1);
    localparam logic [ROW_W-1:0] POOL_ROW_LAST = ROW_W'(2 * OUT_H - 1);

    typedef enum logic {
        S_EVEN = 1'b0,
        S_ODD  = 1'b1
    } state_t;

    state_t                    state;
    logic [COL_W-1:0]          col;
    logic [ROW_W-1:0]          row;
    logic signed [DATA_W-1:0]  pair_reg;
    logic signed [DATA_W-1:0]  linebuf [LB_D];

    logic signed [DATA_W-1:0]  sample;
    logic signed [DATA_W-1:0]  lb_rd;
    logic signed [DATA_W-1:0]  pair_max;
    logic signed [DATA_W-1:0]  win_max;
    logic signed [DATA_W-1:0]  result;
    logic [LB_AW-1:0]          lb_idx;
    logic                      accept;
    logic                      col_odd;
    logic                      col_wrap;
    logic                      frame_end;
    logic                      row_keep;
    logic                      lb_we;
    logic                      out_fire;
    logic                      out_last;

    function automatic logic signed [DATA_W-1:0] smax(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    always_comb begin
        sample    = signed'(conv_out);
        // conv_finish outranks acceptance: a sample on the resync edge is dropped.
        accept    = !conv_invalid && !conv_finish;
        col_odd   = col[0];
        col_wrap  = (col == COL_LAST);
        frame_end = col_wrap && (row == ROW_LAST);
        // A trailing unpaired row (odd IN_H) must never touch the line buffer.
        row_keep  = !(H_ODD && (row == ROW_LAST));
        lb_idx    = LB_AW'(col >> 1);
        lb_rd     = linebuf[lb_idx];
        pair_max  = smax(pair_reg, sample);
        win_max   = smax(lb_rd, pair_max);
`ifdef MAXPOOL_RELU_EN
        result    = win_max[DATA_W-1] ? '0 : win_max;
`else
        result    = win_max;
`endif
        // Odd columns always have a partner, so only the row needs qualifying.
        lb_we     = accept && (state == S_EVEN) && col_odd && row_keep;
        out_fire  = accept && (state == S_ODD) && col_odd;
        out_last  = out_fire && (row == POOL_ROW_LAST) && (col == POOL_COL_LAST);
    end

    // Line buffer has no reset; every entry is written on an even row before
    // the following odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf[lb_idx] <= pair_max;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_EVEN;
            col          <= '0;
            row          <= '0;
            pair_reg     <= '0;
            pool_out     <= '0;
            pool_invalid <= 1'b1;
            pool_finish  <= 1'b0;
        end else begin
            pool_invalid <= 1'b1;
            pool_finish  <= 1'b0;

            if (conv_finish) begin
                state    <= S_EVEN;
                col      <= '0;
                row      <= '0;
                pair_reg <= '0;
            end else if (accept) begin
                // Even column: hold the left half of the pair. The discarded
                // trailing column of an odd-width row may load it too; it is
                // never consumed because the next sample starts a new row.
                if (!col_odd) begin
                    pair_reg <= sample;
                end

                if (out_fire) begin
                    pool_out     <= result;
                    pool_invalid <= 1'b0;
                    pool_finish  <= out_last;
                end

                if (col_wrap) begin
                    col <= '0;
                    if (frame_end) begin
                        row   <= '0;
                        state <= S_EVEN;
                    end else begin
                        row   <= row + 1'b1;
                        state <= (state == S_EVEN) ? S_ODD : S_EVEN;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2x2.sv
module tb_maxpool2x2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int total = 0;
    int bad   = 0;

    // DUT A: nominal 26x26
    logic        reset_a, inv_a, fin_a;
    logic [31:0] in_a;
    logic [31:0] out_a;
    logic        pinv_a, pfin_a;

    // DUT B: odd 5x5
    logic        reset_b, inv_b, fin_b;
    logic [31:0] in_b;
    logic [31:0] out_b;
    logic        pinv_b, pfin_b;

    maxpool2x2 #(.DATA_W(32), .IN_W(26), .IN_H(26)) dut_a (
        .clk(clk), .reset(reset_a), .conv_out(in_a), .conv_invalid(inv_a),
        .conv_finish(fin_a), .pool_out(out_a), .pool_invalid(pinv_a),
        .pool_finish(pfin_a)
    );

    maxpool2x2 #(.DATA_W(32), .IN_W(5), .IN_H(5)) dut_b (
        .clk(clk), .reset(reset_b), .conv_out(in_b), .conv_invalid(inv_b),
        .conv_finish(fin_b), .pool_out(out_b), .pool_invalid(pinv_b),
        .pool_finish(pfin_b)
    );

    typedef struct {
        int val;
        bit fin;
        int due;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Reference model state per DUT (index 0 = A, 1 = B)
    int mem [2][26][26];
    int mr [2];
    int mc [2];
    int dim_w [2] = '{26, 5};
    int dim_h [2] = '{26, 5};

    int n_out_a, n_fin_a, first_a, last_a;
    int n_out_b, n_fin_b;
    int outs_b[$];

    function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Drive one cycle of inputs on the falling edge and update the model.
    task automatic drive(input int sel, input int val, input bit inv,
                         input bit fin, input bit rst);
        exp_t e;
        int w, h, r, c, m;
        @(negedge clk);
        if (sel == 0) begin
            reset_a = rst; in_a = val; inv_a = inv; fin_a = fin;
        end else begin
            reset_b = rst; in_b = val; inv_b = inv; fin_b = fin;
        end
        w = dim_w[sel];
        h = dim_h[sel];
        if (rst || fin) begin
            mr[sel] = 0;
            mc[sel] = 0;
        end else if (!inv) begin
            r = mr[sel];
            c = mc[sel];
            mem[sel][r][c] = val;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                m = imax(imax(mem[sel][r-1][c-1], mem[sel][r-1][c]),
                         imax(mem[sel][r][c-1], mem[sel][r][c]));
                e.val = relu(m);
                e.fin = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
                e.due = cyc + 1;
                if (sel == 0) qa.push_back(e);
                else          qb.push_back(e);
            end
            if (c == w - 1) begin
                mc[sel] = 0;
                mr[sel] = (r == h - 1) ? 0 : r + 1;
            end else begin
                mc[sel] = c + 1;
            end
        end
    endtask

    task automatic idle(input int sel, input int n);
        for (int i = 0; i < n; i++) drive(sel, 0, 1'b1, 1'b0, 1'b0);
    endtask

    // Ramp samples (row*W + col) continuing from the model position.
    task automatic send_ramp(input int sel, input int n, input bit gap);
        int sent = 0;
        int k = 0;
        while (sent < n) begin
            if (gap && (k % 3 == 2)) begin
                drive(sel, 0, 1'b1, 1'b0, 1'b0);
            end else begin
                drive(sel, mr[sel] * dim_w[sel] + mc[sel], 1'b0, 1'b0, 1'b0);
                sent++;
            end
            k++;
        end
    endtask

    // Scoreboard: pop and compare whenever a DUT presents a result.
    always @(negedge clk) begin
        exp_t e;
        if (pinv_a === 1'b0) begin
            n_out_a++;
            if (n_out_a == 1) first_a = int'(out_a);
            last_a = int'(out_a);
            if (pfin_a === 1'b1) n_fin_a++;
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL sb_a_unexpected: got out=%0d with nothing expected at cycle %0d",
                         $signed(out_a), cyc);
            end else begin
                e = qa.pop_front();
                if (out_a !== e.val || pfin_a !== e.fin || cyc != e.due) begin
                    bad++;
                    $display("FAIL sb_a: got out=%0d fin=%0b cyc=%0d, want out=%0d fin=%0b cyc=%0d",
                             $signed(out_a), pfin_a, cyc, e.val, e.fin, e.due);
                end
            end
        end else if (pfin_a !== 1'b0) begin
            bad++;
            $display("FAIL stray_finish_a: got pool_finish=%0b with pool_invalid=%0b, want 0",
                     pfin_a, pinv_a);
        end

        if (pinv_b === 1'b0) begin
            n_out_b++;
            outs_b.push_back(int'(out_b));
            if (pfin_b === 1'b1) n_fin_b++;
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL sb_b_unexpected: got out=%0d with nothing expected at cycle %0d",
                         $signed(out_b), cyc);
            end else begin
                e = qb.pop_front();
                if (out_b !== e.val || pfin_b !== e.fin || cyc != e.due) begin
                    bad++;
                    $display("FAIL sb_b: got out=%0d fin=%0b cyc=%0d, want out=%0d fin=%0b cyc=%0d",
                             $signed(out_b), pfin_b, cyc, e.val, e.fin, e.due);
                end
            end
        end else if (pfin_b !== 1'b0) begin
            bad++;
            $display("FAIL stray_finish_b: got pool_finish=%0b with pool_invalid=%0b, want 0",
                     pfin_b, pinv_b);
        end
    end

    task automatic clear_a();
        n_out_a = 0; n_fin_a = 0; first_a = 0; last_a = 0;
    endtask

    task automatic test_reset();
        drive(0, 0, 1'b1, 1'b0, 1'b1);
        drive(1, 0, 1'b1, 1'b0, 1'b1);
        drive(0, 0, 1'b1, 1'b0, 1'b1);
        total++;
        if (out_a !== 32'd0 || pinv_a !== 1'b1 || pfin_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_a: got out=%0d inv=%0b fin=%0b, want 0/1/0", out_a, pinv_a, pfin_a);
        end
        total++;
        if (out_b !== 32'd0 || pinv_b !== 1'b1 || pfin_b !== 1'b0) begin
            bad++;
            $display("FAIL reset_b: got out=%0d inv=%0b fin=%0b, want 0/1/0", out_b, pinv_b, pfin_b);
        end
        idle(0, 1);
        idle(1, 1);
    endtask

    task automatic check_frame_a(input string name);
        total++;
        if (n_out_a != 169 || n_fin_a != 1 || first_a != 27 || last_a != 675) begin
            bad++;
            $display("FAIL %s: got n=%0d fin=%0d first=%0d last=%0d, want 169/1/27/675",
                     name, n_out_a, n_fin_a, first_a, last_a);
        end
        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL %s_pending: got %0d outputs never produced, want 0", name, qa.size());
        end
    endtask

    task automatic test_ramp();
        clear_a();
        send_ramp(0, 26 * 26, 1'b0);
        idle(0, 3);
        check_frame_a("ramp");
    endtask

    task automatic test_signed();
        int want;
`ifdef MAXPOOL_RELU_EN
        want = 0;
`else
        want = -2;
`endif
        drive(0, -5, 1'b0, 1'b0, 1'b0);
        drive(0, -2, 1'b0, 1'b0, 1'b0);
        for (int c = 2; c < 26; c++) drive(0, 100, 1'b0, 1'b0, 1'b0);
        drive(0, -9, 1'b0, 1'b0, 1'b0);
        drive(0, -3, 1'b0, 1'b0, 1'b0);
        idle(0, 1);
        total++;
        if (pinv_a !== 1'b0 || $signed(out_a) !== want) begin
            bad++;
            $display("FAIL signed: got out=%0d inv=%0b, want out=%0d inv=0",
                     $signed(out_a), pinv_a, want);
        end
        drive(0, 0, 1'b1, 1'b1, 1'b0);
        idle(0, 2);
    endtask

    task automatic test_gapped();
        clear_a();
        send_ramp(0, 26 * 26, 1'b1);
        idle(0, 3);
        check_frame_a("gapped");
    endtask

    task automatic test_resync();
        clear_a();
        send_ramp(0, 300, 1'b0);
        idle(0, 2);
        // Rows 0..9 give 5x13 windows; row 11 cols 0..13 closes 7 more.
        total++;
        if (n_out_a != 72 || n_fin_a != 0) begin
            bad++;
            $display("FAIL resync_partial: got n=%0d fin=%0d, want 72/0", n_out_a, n_fin_a);
        end
        // The sample presented with the pulse must be dropped.
        drive(0, 12345, 1'b0, 1'b1, 1'b0);
        clear_a();
        send_ramp(0, 26 * 26, 1'b0);
        idle(0, 3);
        check_frame_a("resync");
    endtask

    task automatic test_reset_mid();
        send_ramp(0, 400, 1'b0);
        drive(0, 0, 1'b1, 1'b0, 1'b1);
        drive(0, 0, 1'b0, 1'b0, 1'b1);
        total++;
        if (out_a !== 32'd0 || pinv_a !== 1'b1 || pfin_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got out=%0d inv=%0b fin=%0b, want 0/1/0", out_a, pinv_a, pfin_a);
        end
        clear_a();
        send_ramp(0, 26 * 26, 1'b0);
        idle(0, 3);
        check_frame_a("reset_mid");
    endtask

    task automatic test_odd_dims();
        int want [4] = '{6, 8, 16, 18};
        n_out_b = 0;
        n_fin_b = 0;
        outs_b.delete();
        send_ramp(1, 25, 1'b0);
        idle(1, 3);
        total++;
        if (n_out_b != 4 || n_fin_b != 1 || qb.size() != 0) begin
            bad++;
            $display("FAIL odd_count: got n=%0d fin=%0d pending=%0d, want 4/1/0",
                     n_out_b, n_fin_b, qb.size());
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= outs_b.size()) begin
                bad++;
                $display("FAIL odd_val%0d: got no output, want %0d", i, want[i]);
            end else if (outs_b[i] != want[i]) begin
                bad++;
                $display("FAIL odd_val%0d: got %0d, want %0d", i, outs_b[i], want[i]);
            end
        end
        // Second frame confirms the trailing row/column left no residue.
        send_ramp(1, 25, 1'b0);
        idle(1, 3);
        total++;
        if (n_out_b != 8 || n_fin_b != 2) begin
            bad++;
            $display("FAIL odd_second: got n=%0d fin=%0d, want 8/2", n_out_b, n_fin_b);
        end
    endtask

    initial begin
        reset_a = 1'b1; in_a = '0; inv_a = 1'b1; fin_a = 1'b0;
        reset_b = 1'b1; in_b = '0; inv_b = 1'b1; fin_b = 1'b0;
        n_out_a = 0; n_fin_a = 0; first_a = 0; last_a = 0;
        n_out_b = 0; n_fin_b = 0;
        mr = '{0, 0};
        mc = '{0, 0};

        test_reset();
        test_ramp();
        test_signed();
        test_gapped();
        test_resync();
        test_reset_mid();
        test_odd_dims();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
